// File: rtl/pipe_pkg.sv
// Shared types for the RV32I pipeline hazard controller: FSM state encoding,
// forwarding select encoding and the hard-wired zero register index.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam int REG_X0 = 0;

endpackage

// File: rtl/fwd_unit.sv
// Combinational ALU operand forwarding compare for both EX source operands.
// The MEM-stage result is preferred over WB; x0 is never forwarded.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_ruwr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_ruwr,
    output fwd_sel_e          fwd_a,
    output fwd_sel_e          fwd_b
);

    logic [REG_AW-1:0] src [2];
    fwd_sel_e          sel [2];

    assign src[0] = ex_rs1;
    assign src[1] = ex_rs2;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_op
        logic mem_hit;
        logic wb_hit;

        assign mem_hit = mem_ruwr && (mem_rd != REG_AW'(REG_X0)) && (mem_rd == src[gi]);
        assign wb_hit  = wb_ruwr  && (wb_rd  != REG_AW'(REG_X0)) && (wb_rd  == src[gi]);
        assign sel[gi] = mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);
    end

    assign fwd_a = sel[0];
    assign fwd_b = sel[1];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I core: forwarding, load-use
// stalls, redirect flushes and DM-wait freeze with timeout. Optional perf counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int WAIT_TIMEOUT = 16
`ifdef HAZARD_PERF_CNT_EN
    ,parameter int CNT_W       = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_ruwr,
    input  logic              ex_dmrd,
    input  logic              ex_redirect,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_ruwr,
    input  logic              wb_ruwr,
    input  logic              mem_dm_req,
    input  logic              dm_ready,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              dm_abort,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt,
    output logic [CNT_W-1:0]  perf_wait_cnt,
`endif
    output logic [1:0]        state_o
);

    localparam int CW = $clog2(WAIT_TIMEOUT + 1);

    hz_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dm_abort_q, dm_abort_d;
    logic [4:0]    en;
    logic [1:0]    fl;
    logic          lu, mw, run_rules, lu_chk;
    fwd_sel_e      fwd_a_w, fwd_b_w;

    fwd_unit #(.REG_AW(REG_AW)) u_fwd (
        .ex_rs1   (ex_rs1),
        .ex_rs2   (ex_rs2),
        .mem_rd   (mem_rd),
        .mem_ruwr (mem_ruwr),
        .wb_rd    (wb_rd),
        .wb_ruwr  (wb_ruwr),
        .fwd_a    (fwd_a_w),
        .fwd_b    (fwd_b_w)
    );

    assign fwd_a = rst_n ? fwd_a_w : FWD_RF;
    assign fwd_b = rst_n ? fwd_b_w : FWD_RF;

    assign lu = ex_dmrd && ex_ruwr && (ex_rd != REG_AW'(REG_X0)) &&
                ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
    assign mw = mem_dm_req && !dm_ready;

    always_comb begin
        en        = 5'b11111;
        fl        = 2'b00;
        state_d   = RUN;
        cnt_d     = '0;
        run_rules = 1'b0;
        lu_chk    = 1'b0;
        case (state_q)
            RUN: begin
                run_rules = 1'b1;
                lu_chk    = 1'b1;
            end
            // EX holds the bubble now, so the load-use check would be stale.
            LU_STALL: run_rules = 1'b1;
            MEM_WAIT: begin
                // The abort has already been signalled; it wins even if dm_ready arrives late.
                if (dm_abort_q) begin
                    en = 5'b00011;
                end else if (!dm_ready) begin
                    en      = 5'b00000;
                    state_d = MEM_WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    run_rules = 1'b1;
                    lu_chk    = 1'b1;
                end
            end
            default: ;
        endcase
        if (run_rules) begin
            if (mw) begin
                en      = 5'b00000;
                state_d = MEM_WAIT;
                cnt_d   = CW'(1);
            end else if (ex_redirect) begin
                fl = 2'b11;
            end else if (lu_chk && lu) begin
                en      = 5'b00111;
                fl      = 2'b01;
                state_d = LU_STALL;
            end
        end
        if (!rst_n) begin
            en = 5'b00000;
            fl = 2'b11;
        end
    end

    // Registered one cycle ahead so the pulse lines up with the WAIT_TIMEOUT-th wait cycle.
    assign dm_abort_d = (state_d == MEM_WAIT) && (cnt_d == CW'(WAIT_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            dm_abort_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dm_abort_q <= dm_abort_d;
        end
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en;
    assign {ifid_flush, idex_flush} = fl;
    assign dm_abort = dm_abort_q;
    assign state_o  = state_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_wait_cnt  <= '0;
        end else begin
            if (state_q == LU_STALL && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            // Outside reset only a redirect raises ifid_flush.
            if (ifid_flush && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            if (state_q == MEM_WAIT && perf_wait_cnt != '1)
                perf_wait_cnt <= perf_wait_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (WAIT_TIMEOUT=4),
// plus hand-written reset-during-wait and reset-during-stall sequences.
module tb_pipeline_hazard_ctrl;

    localparam int ALL  = 'b11111;
    localparam int NONE = 'b00000;
    localparam int LUE  = 'b00111;
    localparam int ABE  = 'b00011;
    localparam int NV   = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_ruwr, ex_dmrd, ex_redirect;
    logic       mem_ruwr, wb_ruwr, mem_dm_req, dm_ready;
    logic [1:0] fwd_a, fwd_b, state_o;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, dm_abort;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(5), .WAIT_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_ruwr     (ex_ruwr),
        .ex_dmrd     (ex_dmrd),
        .ex_redirect (ex_redirect),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .mem_rd      (mem_rd),
        .wb_rd       (wb_rd),
        .mem_ruwr    (mem_ruwr),
        .wb_ruwr     (wb_ruwr),
        .mem_dm_req  (mem_dm_req),
        .dm_ready    (dm_ready),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .dm_abort    (dm_abort),
        .state_o     (state_o)
    );

    typedef struct {
        logic [4:0] id_rs1;
        logic       id_use_rs1;
        logic [4:0] id_rs2;
        logic       id_use_rs2;
        logic [4:0] ex_rd;
        logic       ex_ruwr;
        logic       ex_dmrd;
        logic       ex_redirect;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] mem_rd;
        logic       mem_ruwr;
        logic [4:0] wb_rd;
        logic       wb_ruwr;
        logic       mem_dm_req;
        logic       dm_ready;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
        logic [4:0] e_en;
        logic [1:0] e_fl;
        logic       e_ab;
        logic [1:0] e_st;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input int r1, u1, r2, u2, exrd, exwr, exld, redir,
                                exs1, exs2, mrd, mwr, wrd, wwr, req, rdy,
                                fa, fb, en, fl, ab, st);
        vec_t v;
        v.id_rs1 = 5'(r1);      v.id_use_rs1 = 1'(u1);
        v.id_rs2 = 5'(r2);      v.id_use_rs2 = 1'(u2);
        v.ex_rd = 5'(exrd);     v.ex_ruwr = 1'(exwr);
        v.ex_dmrd = 1'(exld);   v.ex_redirect = 1'(redir);
        v.ex_rs1 = 5'(exs1);    v.ex_rs2 = 5'(exs2);
        v.mem_rd = 5'(mrd);     v.mem_ruwr = 1'(mwr);
        v.wb_rd = 5'(wrd);      v.wb_ruwr = 1'(wwr);
        v.mem_dm_req = 1'(req); v.dm_ready = 1'(rdy);
        v.e_fa = 2'(fa);        v.e_fb = 2'(fb);
        v.e_en = 5'(en);        v.e_fl = 2'(fl);
        v.e_ab = 1'(ab);        v.e_st = 2'(st);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rs1 = v.id_rs1;         id_use_rs1 = v.id_use_rs1;
        id_rs2 = v.id_rs2;         id_use_rs2 = v.id_use_rs2;
        ex_rd = v.ex_rd;           ex_ruwr = v.ex_ruwr;
        ex_dmrd = v.ex_dmrd;       ex_redirect = v.ex_redirect;
        ex_rs1 = v.ex_rs1;         ex_rs2 = v.ex_rs2;
        mem_rd = v.mem_rd;         mem_ruwr = v.mem_ruwr;
        wb_rd = v.wb_rd;           wb_ruwr = v.wb_ruwr;
        mem_dm_req = v.mem_dm_req; dm_ready = v.dm_ready;
    endtask

    task automatic chk(input string tag, input int idx, input string nm,
                       input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] %s: got %b expected %b", tag, idx, nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int idx, input vec_t v);
        chk(tag, idx, "fwd_a", {3'b000, fwd_a}, {3'b000, v.e_fa});
        chk(tag, idx, "fwd_b", {3'b000, fwd_b}, {3'b000, v.e_fb});
        chk(tag, idx, "enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, v.e_en);
        chk(tag, idx, "flushes", {3'b000, ifid_flush, idex_flush}, {3'b000, v.e_fl});
        chk(tag, idx, "dm_abort", {4'b0000, dm_abort}, {4'b0000, v.e_ab});
        chk(tag, idx, "state", {3'b000, state_o}, {3'b000, v.e_st});
        $display("%s %0d: fwd=%b/%b en=%b fl=%b ab=%b st=%b", tag, idx, fwd_a, fwd_b,
                 {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {ifid_flush, idex_flush},
                 dm_abort, state_o);
    endtask

    initial begin
        //            id_rs1/use id_rs2/use ex_rd wr ld rdr ex_rs1/2 mem_rd/wr wb_rd/wr req rdy | fa fb en fl ab st
        vecs[0]  = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 0,0,0);
        vecs[1]  = mk(0,0, 0,0, 0,0,0,0, 5,3, 5,1, 5,1, 0,0, 2,0,ALL, 0,0,0);
        vecs[2]  = mk(0,0, 0,0, 0,0,0,0, 6,6, 0,0, 6,1, 0,0, 1,1,ALL, 0,0,0);
        vecs[3]  = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,1, 0,1, 0,0, 0,0,ALL, 0,0,0);
        vecs[4]  = mk(0,0, 0,0, 0,0,0,0, 1,9, 9,0, 9,1, 0,0, 0,1,ALL, 0,0,0);
        vecs[5]  = mk(2,1, 7,1, 7,1,1,0, 0,0, 0,0, 0,0, 0,0, 0,0,LUE, 1,0,0);
        vecs[6]  = mk(2,1, 7,1, 7,1,1,0, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 0,0,1);
        vecs[7]  = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 0,0,0);
        vecs[8]  = mk(2,1, 7,0, 7,1,1,0, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 0,0,0);
        vecs[9]  = mk(0,1, 7,0, 0,1,1,0, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 0,0,0);
        vecs[10] = mk(2,1, 7,1, 7,1,1,1, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 3,0,0);
        vecs[11] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 0,0,0);
        vecs[12] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,0, 0,0,NONE,0,0,0);
        vecs[13] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,0, 0,0,NONE,0,0,2);
        vecs[14] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,0, 0,0,NONE,0,0,2);
        vecs[15] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,1, 0,0,ALL, 0,0,2);
        vecs[16] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 0,0,0);
        vecs[17] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,0, 0,0,NONE,0,0,0);
        vecs[18] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,0, 0,0,NONE,0,0,2);
        vecs[19] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,0, 0,0,NONE,0,0,2);
        vecs[20] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,0, 0,0,NONE,0,0,2);
        vecs[21] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,0, 0,0,ABE, 0,1,2);
        vecs[22] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 0,0,0);
        vecs[23] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,0, 0,0,NONE,0,0,0);
        vecs[24] = mk(2,1, 7,1, 7,1,1,0, 0,0, 0,0, 0,0, 1,1, 0,0,LUE, 1,0,2);
        vecs[25] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 0,0,1);
        vecs[26] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 0,0,0);
        vecs[27] = mk(0,0, 0,0, 0,0,0,1, 0,0, 0,0, 0,0, 1,0, 0,0,NONE,0,0,0);
        vecs[28] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 1,1, 0,0,ALL, 0,0,2);
        vecs[29] = mk(0,0, 0,0, 0,0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0,ALL, 0,0,0);

        // Reset held with forwarding inputs active: outputs must sit at reset values.
        drive(vecs[1]);
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 0, mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0,NONE,3,0,0));
        @(negedge clk);
        drive(vecs[0]);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #4;
            check_outs("row", i, vecs[i]);
        end

        // Reset in the middle of a DM wait.
        @(negedge clk);
        drive(vecs[12]);
        repeat (2) @(negedge clk);
        #4;
        check_outs("rst_wait", 0, mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0,NONE,0,0,2));
        #1 rst_n = 1'b0;
        #1;
        check_outs("rst_wait", 1, mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0,NONE,3,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(vecs[0]);
        #4;
        check_outs("rst_wait", 2, vecs[0]);

        // Reset in the middle of a load-use stall: no stall is remembered.
        @(negedge clk);
        drive(vecs[5]);
        #4;
        check_outs("rst_stall", 0, vecs[5]);
        @(negedge clk);
        drive(vecs[0]);
        #1;
        check_outs("rst_stall", 1, mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0,ALL,0,0,1));
        rst_n = 1'b0;
        #1;
        check_outs("rst_stall", 2, mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0,NONE,3,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        check_outs("rst_stall", 3, vecs[0]);
        @(negedge clk);
        #4;
        check_outs("rst_stall", 4, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
